// File: rtl/lut_seq_accum_if.sv
// Start/done handshake, operands and result of the LUT sequence accumulator.
// The master side issues operations; the slave side is the accumulator itself.
interface lut_seq_accum_if #(
  parameter int IDX_W = 5,
  parameter int RET_W = 12
);
  logic             ap_start;
  logic             ap_done;
  logic             ap_idle;
  logic             ap_ready;
  logic [IDX_W-1:0] index_V;
  logic             mode_V;
  logic [RET_W-1:0] ap_return;

  modport master (
    output ap_start, index_V, mode_V,
    input  ap_done, ap_idle, ap_ready, ap_return
  );

  modport slave (
    input  ap_start, index_V, mode_V,
    output ap_done, ap_idle, ap_ready, ap_return
  );
endinterface

// File: rtl/lut_seq_accum.sv
// Sequential accumulator: sums k or k*k for k = 0..N, one term per clock.
// The result register holds its value until the next completion or reset.
//
// state | meaning
// IDLE  | waiting for ap_start; operands are captured on the start edge
// RUN   | adds term(k) each cycle, N+1 cycles in total
// DONE  | one-cycle ap_done/ap_ready pulse, result already in ap_return
module lut_seq_accum #(
  parameter int IDX_W = 5,
  parameter int RET_W = 12
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  lut_seq_accum_if.slave    s_bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [IDX_W-1:0]   r_n;
  logic [IDX_W-1:0]   r_k;
  logic               r_m;
  logic [RET_W-1:0]   r_acc;
  logic [RET_W-1:0]   r_ret;

  logic [2*IDX_W-1:0] w_k_ext;
  logic [2*IDX_W-1:0] w_sq;
  logic [RET_W-1:0]   w_term;
  logic [RET_W-1:0]   w_acc_sum;
  logic               w_last;
  logic               w_idle;
  logic               w_done;

  // Square is formed at full 2*IDX_W width, then truncated/extended to RET_W.
  assign w_k_ext   = {{IDX_W{1'b0}}, r_k};
  assign w_sq      = w_k_ext * w_k_ext;
  assign w_term    = RET_W'(r_m ? w_sq : w_k_ext);
  assign w_acc_sum = r_acc + w_term;
  assign w_last    = (r_k == r_n);

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idle      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      IDLE: begin
        w_idle = 1'b1;
        if (s_bus.ap_start) begin
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        if (w_last) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        w_done      = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_n   <= '0;
      r_k   <= '0;
      r_m   <= 1'b0;
      r_acc <= '0;
      r_ret <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (s_bus.ap_start) begin
            r_n   <= s_bus.index_V;
            r_m   <= s_bus.mode_V;
            r_acc <= '0;
            r_k   <= '0;
          end
        end
        RUN: begin
          r_acc <= w_acc_sum;
          if (w_last) begin
            r_ret <= w_acc_sum;
          end else begin
            r_k <= r_k + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Handshake outputs depend on the state register only.
  assign s_bus.ap_idle   = w_idle;
  assign s_bus.ap_done   = w_done;
  assign s_bus.ap_ready  = w_done;
  assign s_bus.ap_return = r_ret;

endmodule

// File: tb/tb_lut_seq_accum.sv
// Randomized and directed bench for lut_seq_accum against an arithmetic reference sum.
module tb_lut_seq_accum;
  localparam int IDX_W = 5;
  localparam int RET_W = 12;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk  = 0;
  int   n_pass = 0;

  lut_seq_accum_if #(.IDX_W(IDX_W), .RET_W(RET_W)) bus ();

  lut_seq_accum #(.IDX_W(IDX_W), .RET_W(RET_W)) u_dut (
    .ap_clk   (clk),
    .ap_rst_n (rst_n),
    .s_bus    (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint unsigned got, input longint unsigned exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic longint unsigned ref_sum(input int unsigned n, input bit m);
    longint unsigned s = 0;
    for (int unsigned k = 0; k <= n; k++) s += m ? k * k : k;
    return s % (64'd1 << RET_W);
  endfunction

  task automatic scramble();
    bus.index_V = IDX_W'($urandom);
    bus.mode_V  = 1'($urandom);
  endtask

  // Issues one operation; lat counts clock edges after the start edge until
  // ap_done is seen, so a consumer registers the pulse on edge N+2.
  task automatic run_op(input int unsigned n, input bit m, input string tag, input bit drive_now);
    int lat;
    bit seen;
    if (!drive_now) @(negedge clk);
    bus.ap_start = 1'b1;
    bus.index_V  = IDX_W'(n);
    bus.mode_V   = m;
    @(posedge clk);
    @(negedge clk);
    bus.ap_start = 1'b0;
    scramble();
    chk({tag, " busy"}, bus.ap_idle, 0);
    lat  = 0;
    seen = bus.ap_done;
    while (!seen && lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      scramble();
      seen = bus.ap_done;
    end
    chk({tag, " done"}, seen, 1);
    chk({tag, " lat"}, lat, n + 1);
    chk({tag, " ready"}, bus.ap_ready, 1);
    chk({tag, " ret"}, bus.ap_return, ref_sum(n, m));
    @(negedge clk);
    chk({tag, " idle_after"}, bus.ap_idle, 1);
    chk({tag, " done_low"}, bus.ap_done, 0);
  endtask

  initial begin
    int pulses;
    int cyc;
    bus.ap_start = 1'b0;
    bus.index_V  = '0;
    bus.mode_V   = 1'b0;

    #1;
    chk("rst idle", bus.ap_idle, 1);
    chk("rst done", bus.ap_done, 0);
    chk("rst ready", bus.ap_ready, 0);
    chk("rst ret", bus.ap_return, 0);

    // Start is presented on the very first edge after reset release.
    @(negedge clk);
    rst_n = 1'b1;
    run_op(2, 1'b0, "post_rst", 1'b1);

    for (int n = 0; n < 32; n++) run_op(n, 1'b0, $sformatf("sumk%0d", n), 1'b0);
    run_op(10, 1'b1, "sq10", 1'b0);
    run_op(31, 1'b1, "sq31_wrap", 1'b0);
    run_op(0, 1'b1, "sq0", 1'b0);

    repeat (20) run_op($urandom_range(0, 31), 1'($urandom_range(0, 1)), "rand", 1'b0);

    // ap_start held high across a whole operation, operands toggled mid-run.
    @(negedge clk);
    bus.ap_start = 1'b1;
    bus.index_V  = 5'd5;
    bus.mode_V   = 1'b0;
    pulses = 0;
    cyc    = 0;
    do begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
      scramble();
      pulses += int'(bus.ap_done);
      if (bus.ap_done) chk("busy ret", bus.ap_return, ref_sum(5, 0));
    end while (!bus.ap_idle && cyc < 100);
    chk("busy pulses", pulses, 1);
    chk("busy idle_cyc", cyc, 8);
    bus.index_V = 5'd4;
    bus.mode_V  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.ap_start = 1'b0;
    chk("busy restart", bus.ap_idle, 0);
    cyc = 0;
    while (!bus.ap_done && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("busy second_done", bus.ap_done, 1);
    chk("busy second_ret", bus.ap_return, ref_sum(4, 1));
    @(negedge clk);

    // Reset in the middle of RUN aborts the operation and clears the result.
    run_op(6, 1'b0, "pre_abort", 1'b0);
    @(negedge clk);
    bus.ap_start = 1'b1;
    bus.index_V  = 5'd20;
    bus.mode_V   = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.ap_start = 1'b0;
    pulses = 0;
    repeat (8) begin
      @(posedge clk);
      @(negedge clk);
      pulses += int'(bus.ap_done);
    end
    chk("abort held_ret", bus.ap_return, ref_sum(6, 0));
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort idle", bus.ap_idle, 1);
    chk("abort ret", bus.ap_return, 0);
    chk("abort done", bus.ap_done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (25) begin
      @(negedge clk);
      pulses += int'(bus.ap_done);
    end
    chk("abort pulses", pulses, 0);
    run_op(3, 1'b1, "after_abort", 1'b0);

    // Result holds across a long idle period with operand noise.
    run_op(31, 1'b0, "hold_src", 1'b0);
    pulses = 0;
    repeat (50) begin
      @(negedge clk);
      scramble();
      chk("hold ret", bus.ap_return, 496);
      pulses += int'(bus.ap_done);
    end
    chk("hold pulses", pulses, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
